// File: rtl/udp_box_sched.sv
`default_nettype none
// ============================================================================
// Module      : udp_box_sched
// Description : Double-buffered box-descriptor scheduler. Packed 48-bit
//               descriptors {start_x[10:0], start_y[9:0], end_x[10:0],
//               end_y[9:0], color[5:0]} arrive from the UDP deframer and are
//               written into one bank while the other bank is replayed to
//               the overlay drawer once per video frame. A complete packet
//               only becomes visible at the next frame start, so the overlay
//               never shows a half-updated list.
//
// Ports       : clk, rst          clock, synchronous active-high reset
//               i_vsync           frame sync level, rising edge = frame start
//               i_valid/i_data/i_last/o_ready   descriptor input handshake
//               o_valid/o_data/o_idx/o_last/i_ready   replay output handshake
//               o_count           entries in the replay bank
//               o_overflow        sticky: descriptors dropped in current packet
//
// Options     : UDP_BOX_FILTER_EN - when defined, descriptors with an
//               inverted box or a start point outside 1280x720 are dropped.
//
// Revision    : 1.0 - initial release
// ============================================================================
module udp_box_sched #(
    parameter int MAX_BOX = 16,
    parameter int IDXW    = $clog2(MAX_BOX)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vsync,
    input  logic            i_valid,
    input  logic [47:0]     i_data,
    input  logic            i_last,
    output logic            o_ready,
    output logic            o_valid,
    output logic [47:0]     o_data,
    output logic [IDXW-1:0] o_idx,
    output logic            o_last,
    input  logic            i_ready,
    output logic [IDXW:0]   o_count,
    output logic            o_overflow
);

    localparam int              C_CNTW = IDXW + 1;
    localparam logic [IDXW:0]   C_FULL = C_CNTW'(MAX_BOX);
    localparam logic [IDXW:0]   C_ONE  = C_CNTW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    // Two banks of MAX_BOX entries; the MSB of the address selects the bank.
    logic [47:0]     mem_q [0:2*MAX_BOX-1];

    logic            vsync_q;
    logic            pend_q;
    logic            rd_bank_q;
    logic            ovf_q;
    logic [IDXW:0]   wr_cnt_q;
    logic [IDXW:0]   pend_cnt_q;
    logic [IDXW:0]   count_q;
    logic [IDXW-1:0] idx_q, idx_d;
    state_t          state_q, state_d;
    logic [47:0]     data_q;

    logic            w_fs;
    logic            w_swap;
    logic            w_acc;
    logic            w_keep;
    logic            w_full;
    logic            w_wr;
    logic [IDXW:0]   w_wr_cnt_next;
    logic [IDXW:0]   w_new_count;
    logic            w_new_rd_bank;
    logic            w_xfer;
    logic [IDXW:0]   w_waddr;
    logic [IDXW:0]   w_raddr;

    assign w_fs   = i_vsync & ~vsync_q;
    // The swap cycle blocks input so the write bank is quiet while it flips.
    assign w_swap = w_fs & pend_q;

    assign o_ready = ~rst & ~w_swap;
    assign w_acc   = i_valid & o_ready;

`ifdef UDP_BOX_FILTER_EN
    logic [10:0] w_sx, w_ex;
    logic [9:0]  w_sy, w_ey;
    assign w_sx   = i_data[47:37];
    assign w_sy   = i_data[36:27];
    assign w_ex   = i_data[26:16];
    assign w_ey   = i_data[15:6];
    assign w_keep = ~((w_ex < w_sx) | (w_ey < w_sy) |
                      (w_sx >= 11'd1280) | (w_sy >= 10'd720));
`else
    assign w_keep = 1'b1;
`endif

    assign w_full        = (wr_cnt_q == C_FULL);
    assign w_wr          = w_acc & w_keep & ~w_full;
    assign w_wr_cnt_next = w_wr ? (wr_cnt_q + C_ONE) : wr_cnt_q;

    // List that replays from this frame start on, after any commit.
    assign w_new_count   = w_swap ? pend_cnt_q : count_q;
    assign w_new_rd_bank = rd_bank_q ^ w_swap;

    assign w_waddr = {~rd_bank_q, wr_cnt_q[IDXW-1:0]};
    assign w_raddr = {w_new_rd_bank, idx_d};

    // ------------------------------------------------------------------
    // Write side and commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            pend_q     <= 1'b0;
            rd_bank_q  <= 1'b0;
            ovf_q      <= 1'b0;
            wr_cnt_q   <= '0;
            pend_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            vsync_q <= i_vsync;

            // w_acc and w_swap are mutually exclusive by construction.
            if (w_acc && i_last) begin
                pend_q     <= 1'b1;
                pend_cnt_q <= w_wr_cnt_next;
                wr_cnt_q   <= '0;
            end else begin
                wr_cnt_q   <= w_wr_cnt_next;
            end

            if (w_acc && w_keep && w_full) begin
                ovf_q <= 1'b1;
            end

            if (w_swap) begin
                rd_bank_q <= ~rd_bank_q;
                count_q   <= pend_cnt_q;
                pend_q    <= 1'b0;
                ovf_q     <= 1'b0;
            end
        end
    end

    // Descriptor storage carries no reset; emptiness is tracked by counts.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[w_waddr] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Replay FSM
    // ------------------------------------------------------------------
    assign w_xfer = (state_q == S_PLAY) & i_ready;
    assign o_last = (state_q == S_PLAY) & ({1'b0, idx_q} == (count_q - C_ONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (w_fs) begin
            // Frame start wins over a concurrent transfer: restart at 0.
            idx_d   = '0;
            state_d = (w_new_count != '0) ? S_PLAY : S_IDLE;
        end else if (w_xfer) begin
            if (o_last) begin
                idx_d   = '0;
                state_d = S_IDLE;
            end else begin
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Registered bank read addressed by the next index, so data lines up
    // with o_idx. The replay bank is never written, so a stall holds it.
    always_ff @(posedge clk) begin
        data_q <= mem_q[w_raddr];
    end

    assign o_valid    = (state_q == S_PLAY);
    assign o_data     = data_q;
    assign o_idx      = idx_q;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_box_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_box_sched
// Description : Randomized and directed stimulus for udp_box_sched with a
//               list-level reference model and a replay scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_box_sched;

    localparam int MAX_BOX = 16;
    localparam int IDXW    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_vsync;
    logic            i_valid;
    logic [47:0]     i_data;
    logic            i_last;
    logic            o_ready;
    logic            o_valid;
    logic [47:0]     o_data;
    logic [IDXW-1:0] o_idx;
    logic            o_last;
    logic            i_ready;
    logic [IDXW:0]   o_count;
    logic            o_overflow;

    always #5 clk = ~clk;

    udp_box_sched #(.MAX_BOX(MAX_BOX)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_vsync    (i_vsync),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_idx      (o_idx),
        .o_last     (o_last),
        .i_ready    (i_ready),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    typedef struct {
        logic [47:0] d;
        int          idx;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // Reference model: the replay list, the list being assembled,
    // and the packet bookkeeping.
    logic [47:0] m_act [MAX_BOX];
    logic [47:0] m_wr  [MAX_BOX];
    int          m_wr_cnt, m_pend_cnt, m_count;
    bit          m_pend, m_ovf, m_vs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

`ifdef UDP_BOX_FILTER_EN
    function automatic bit legal(input logic [47:0] d);
        int sx, sy, ex, ey;
        sx = int'(d[47:37]);
        sy = int'(d[36:27]);
        ex = int'(d[26:16]);
        ey = int'(d[15:6]);
        return !(ex < sx || ey < sy || sx >= 1280 || sy >= 720);
    endfunction

    function automatic logic [47:0] mk(input int sx, input int sy, input int ex, input int ey);
        return {11'(sx), 10'(sy), 11'(ex), 10'(ey), 6'd5};
    endfunction
`endif

    // Effect of one clock edge on the model, given the inputs applied.
    task automatic model_edge(input bit r, input bit vs, input bit v,
                              input logic [47:0] d, input bit l);
        bit fs, swap, acc, keep;
        logic [47:0] tmp [MAX_BOX];
        if (r) begin
            m_vs = 0; m_pend = 0; m_ovf = 0;
            m_wr_cnt = 0; m_pend_cnt = 0; m_count = 0;
            exp_q.delete();
            return;
        end
        fs   = vs && !m_vs;
        m_vs = vs;
        swap = fs && m_pend;
        acc  = v && !swap;
        if (acc) begin
`ifdef UDP_BOX_FILTER_EN
            keep = legal(d);
`else
            keep = 1'b1;
`endif
            if (keep) begin
                if (m_wr_cnt < MAX_BOX) begin
                    m_wr[m_wr_cnt] = d;
                    m_wr_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (l) begin
                m_pend     = 1;
                m_pend_cnt = m_wr_cnt;
                m_wr_cnt   = 0;
            end
        end
        if (swap) begin
            tmp    = m_act;
            m_act  = m_wr;
            m_wr   = tmp;
            m_count = m_pend_cnt;
            m_pend = 0;
            m_ovf  = 0;
        end
        if (fs) begin
            exp_q.delete();
            for (int i = 0; i < m_count; i++)
                exp_q.push_back('{d: m_act[i], idx: i, last: (i == m_count - 1)});
        end
    endtask

    // One clock cycle: apply inputs, check handshake/status, advance model.
    task automatic step(input bit r, input bit vs, input bit v,
                        input logic [47:0] d, input bit l, input bit rdy);
        bit fs;
        rst = r; i_vsync = vs; i_valid = v; i_data = d; i_last = l; i_ready = rdy;
        fs = vs && !m_vs;
        #3;
        chk("o_ready", o_ready, 64'(!r && !(fs && m_pend)));
        chk("o_count", o_count, 64'(m_count));
        chk("o_overflow", o_overflow, 64'(m_ovf));
        @(posedge clk);
        model_edge(r, vs, v, d, l);
        #1;
    endtask

    task automatic idle(input int n, input bit vs, input bit rdy);
        for (int i = 0; i < n; i++) step(0, vs, 0, 48'h0, 0, rdy);
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Replay monitor: checks every presented output against the head of
    // the expected list, consuming it on each transfer.
    always @(negedge clk) begin
        chk("o_valid", o_valid, 64'(exp_q.size() > 0));
        if (o_valid === 1'b1 && exp_q.size() > 0) begin
            chk("o_data", o_data, 64'(exp_q[0].d));
            chk("o_idx", o_idx, 64'(exp_q[0].idx));
            chk("o_last", o_last, 64'(exp_q[0].last));
            if (i_ready) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic [47:0] w;
        bit vs_lvl;
        rst = 1; i_vsync = 0; i_valid = 0; i_data = '0; i_last = 0; i_ready = 0;
        @(posedge clk);
        model_edge(1, 0, 0, 48'h0, 0);
        #1;
        step(1, 0, 0, 48'h0, 0, 1);
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_idx", o_idx, 0);
        chk("reset_o_last", o_last, 0);

        // Three frame starts with nothing received.
        for (int k = 0; k < 3; k++) begin
            idle(2, 1, 1);
            idle(3, 0, 1);
        end
        chk("empty_count", o_count, 0);

        // Three-word packet, then frame start.
        step(0, 0, 1, 48'hA0A0_0000_0001, 0, 1);
        step(0, 0, 1, 48'hB0B0_0000_0002, 0, 1);
        step(0, 0, 1, 48'hC0C0_0000_0003, 1, 1);
        step(0, 1, 0, 48'h0, 0, 1);
        chk("count3", o_count, 3);
        idle(6, 1, 1);
        idle(2, 0, 1);

        // Twenty-word packet overflows a 16-entry bank.
        for (int i = 0; i < 20; i++) step(0, 0, 1, rnd48(), (i == 19), 1);
        chk("ovf_set", o_overflow, 1);
        step(0, 1, 0, 48'h0, 0, 1);
        chk("count16", o_count, 16);
        chk("ovf_clear", o_overflow, 0);
        for (int i = 0; i < 25; i++) step(0, 1, 0, 48'h0, 0, ($urandom_range(0, 3) != 0));
        idle(2, 0, 1);

        // Four entries, stalled for five cycles, aborted by a frame start at idx 2.
        for (int i = 0; i < 4; i++) step(0, 0, 1, rnd48(), (i == 3), 1);
        step(0, 1, 0, 48'h0, 0, 0);
        idle(5, 0, 0);
        idle(2, 0, 1);
        chk("abort_idx", o_idx, 2);
        step(0, 1, 0, 48'h0, 0, 0);
        chk("restart_idx", o_idx, 0);
        idle(6, 1, 1);
        idle(2, 0, 1);

        // Pending packet at frame start plus a new i_last arriving in that cycle.
        for (int i = 0; i < 3; i++) step(0, 0, 1, rnd48(), (i == 2), 1);
        w = rnd48();
        step(0, 1, 1, w, 1, 1);
        step(0, 1, 1, w, 1, 1);
        chk("commit_old", o_count, 3);
        idle(5, 1, 1);
        idle(2, 0, 1);
        step(0, 1, 0, 48'h0, 0, 1);
        chk("commit_new", o_count, 1);
        idle(3, 1, 1);
        idle(2, 0, 1);

`ifdef UDP_BOX_FILTER_EN
        step(0, 0, 1, mk(1300, 10, 1400, 20), 0, 1);
        step(0, 0, 1, mk(100, 10, 200, 5), 0, 1);
        step(0, 0, 1, mk(10, 10, 50, 50), 0, 1);
        step(0, 0, 1, mk(0, 0, 1279, 719), 1, 1);
        step(0, 1, 0, 48'h0, 0, 1);
        chk("filter_count", o_count, 2);
        idle(4, 1, 1);
        idle(2, 0, 1);
`endif

        // Randomized traffic with a reset in the middle.
        vs_lvl = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 14) == 0) vs_lvl = !vs_lvl;
            if (i == 300) begin
                step(1, vs_lvl, 1, rnd48(), 1, 1);
                step(1, vs_lvl, 0, 48'h0, 0, 1);
            end else begin
                step(0, vs_lvl, ($urandom_range(0, 3) != 0), rnd48(),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
            end
        end
        idle(30, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
